// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {CS_N,RAS_N,CAS_N,WE_N},
// refresh FSM state enumeration and a state-to-command helper.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_RP,
    ST_AREF,
    ST_WAIT_RFC,
    ST_DONE
  } refr_state_t;

  function automatic logic [3:0] cmd_of(refr_state_t s);
    logic [3:0] c;
    c = CMD_NOP;
    unique case (s)
      ST_PRE:  c = CMD_PRE;
      ST_AREF: c = CMD_AREF;
      default: c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sdram_refr_timer.sv
// Refresh interval timer: counts 0..T_REFI-1 and wraps.
// Ports: clk, rst (sync, active high), tick (high while count is T_REFI-1).
module sdram_refr_timer #(
  parameter int T_REFI = 750
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(T_REFI - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_refr_ctrl.sv
// SDRAM auto-refresh controller: tracks refresh debt, requests the bus and
// issues PRE-all + AREF bursts. Ports: sys_clk, sys_rst, refr_en (grant),
// refr_req/urgent/end/ovf status, refr_cmd, refr_addr, refr_debt.
module sdram_refr_ctrl
  import sdram_pkg::*;
#(
  parameter int T_REFI   = 750,
  parameter int T_RP     = 2,
  parameter int T_RFC    = 7,
  parameter int MAX_DEBT = 8,
  parameter int ADDR_W   = 12,
  parameter int DW       = $clog2(MAX_DEBT + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              refr_en,
  output logic              refr_req,
  output logic              refr_urgent,
  output logic              refr_end,
  output logic              refr_ovf,
  output logic [3:0]        refr_cmd,
  output logic [ADDR_W-1:0] refr_addr,
  output logic [DW-1:0]     refr_debt
);

  localparam int TMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RP_LAST  = TW'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [TW-1:0] RFC_LAST = TW'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [DW-1:0] DEBT_MAX = DW'(MAX_DEBT);

  refr_state_t   state;
  refr_state_t   state_nxt;
  logic [TW-1:0] wcnt;
  logic [TW-1:0] wcnt_nxt;
  logic [DW-1:0] debt_nxt;
  logic          ovf_set;
  logic          tick;
  logic          aref;

  // PRE-all needs A10 high; every other address bit is don't-care, held 0.
  assign refr_addr = ADDR_W'(11'h400);

  sdram_refr_timer #(
    .T_REFI(T_REFI)
  ) u_timer (
    .clk (sys_clk),
    .rst (sys_rst),
    .tick(tick)
  );

  assign aref = (state == ST_AREF);

  // A tick and an AREF on the same clock cancel out.
  always_comb begin
    debt_nxt = refr_debt;
    ovf_set  = 1'b0;
    if (tick && !aref) begin
      if (refr_debt == DEBT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        debt_nxt = refr_debt + 1'b1;
      end
    end else if (aref && !tick && refr_debt != '0) begin
      debt_nxt = refr_debt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      ST_IDLE: begin
        if (refr_en && refr_debt != '0) begin
          state_nxt = ST_PRE;
        end
      end
      ST_PRE: begin
        wcnt_nxt  = '0;
        state_nxt = (T_RP > 1) ? ST_WAIT_RP : ST_AREF;
      end
      ST_WAIT_RP: begin
        if (wcnt == RP_LAST) begin
          state_nxt = ST_AREF;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      ST_AREF: begin
        wcnt_nxt = '0;
        if (T_RFC > 1) begin
          state_nxt = ST_WAIT_RFC;
        end else begin
          state_nxt = (debt_nxt != '0) ? ST_AREF : ST_DONE;
        end
      end
      ST_WAIT_RFC: begin
        if (wcnt == RFC_LAST) begin
          state_nxt = (refr_debt != '0) ? ST_AREF : ST_DONE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Losing the grant abandons the burst; issued AREFs stay counted.
    if (state != ST_IDLE && !refr_en) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Outputs are flopped from next-state so they line up with the state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      refr_debt   <= '0;
      refr_req    <= 1'b0;
      refr_urgent <= 1'b0;
      refr_end    <= 1'b0;
      refr_ovf    <= 1'b0;
      refr_cmd    <= CMD_NOP;
    end else begin
      refr_debt   <= debt_nxt;
      refr_req    <= (debt_nxt != '0);
      refr_urgent <= (debt_nxt == DEBT_MAX);
      refr_end    <= (state_nxt == ST_DONE);
      refr_ovf    <= refr_ovf | ovf_set;
      refr_cmd    <= cmd_of(state_nxt);
    end
  end

endmodule

// File: tb/tb_sdram_refr_ctrl.sv
// Directed self-checking bench for sdram_refr_ctrl
// (T_REFI=20, T_RP=2, T_RFC=4, MAX_DEBT=4).
module tb_sdram_refr_ctrl;
  import sdram_pkg::*;

  localparam int T_REFI   = 20;
  localparam int T_RP     = 2;
  localparam int T_RFC    = 4;
  localparam int MAX_DEBT = 4;
  localparam int ADDR_W   = 12;
  localparam int DW       = 3;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              refr_en = 1'b0;
  logic              refr_req;
  logic              refr_urgent;
  logic              refr_end;
  logic              refr_ovf;
  logic [3:0]        refr_cmd;
  logic [ADDR_W-1:0] refr_addr;
  logic [DW-1:0]     refr_debt;

  int n_cmp = 0;
  int n_err = 0;

  sdram_refr_ctrl #(
    .T_REFI  (T_REFI),
    .T_RP    (T_RP),
    .T_RFC   (T_RFC),
    .MAX_DEBT(MAX_DEBT),
    .ADDR_W  (ADDR_W),
    .DW      (DW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .refr_en    (refr_en),
    .refr_req   (refr_req),
    .refr_urgent(refr_urgent),
    .refr_end   (refr_end),
    .refr_ovf   (refr_ovf),
    .refr_cmd   (refr_cmd),
    .refr_addr  (refr_addr),
    .refr_debt  (refr_debt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    refr_en = 1'b0;
    step(3);
    sys_rst = 1'b0;
  endtask

  // Grant held; PRE at k=1, AREFs at k=3,7,.. ; refr_end at 3+4*n.
  task automatic burst(input string tag, input int n);
    int last;
    logic [3:0] e;
    last = 3 + 4 * n;
    refr_en = 1'b1;
    for (int k = 1; k <= last; k++) begin
      step(1);
      if (k == 1) e = CMD_PRE;
      else if (k >= 3 && k < last && ((k - 3) % 4) == 0) e = CMD_AREF;
      else e = CMD_NOP;
      chk($sformatf("%s_cmd%0d", tag, k), 32'(refr_cmd), 32'(e));
      chk($sformatf("%s_end%0d", tag, k), 32'(refr_end), 32'(k == last));
    end
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst_cmd", 32'(refr_cmd), 32'(CMD_NOP));
    chk("rst_req", 32'(refr_req), 0);
    chk("rst_urg", 32'(refr_urgent), 0);
    chk("rst_end", 32'(refr_end), 0);
    chk("rst_ovf", 32'(refr_ovf), 0);
    chk("rst_debt", 32'(refr_debt), 0);
    chk("rst_addr", 32'(refr_addr), 32'h400);
    chk("rst_timer", 32'(dut.u_timer.cnt), 0);

    // single refresh: first tick lands on edge 20
    step(19);
    chk("one_pre_req", 32'(refr_req), 0);
    step(1);
    chk("one_debt", 32'(refr_debt), 1);
    chk("one_req", 32'(refr_req), 1);
    burst("one", 1);
    chk("one_debt0", 32'(refr_debt), 0);
    chk("one_req0", 32'(refr_req), 0);
    refr_en = 1'b0;
    step(1);
    chk("one_idle_end", 32'(refr_end), 0);
    chk("one_idle_st", 32'(dut.state), 32'(ST_IDLE));

    // postponed refresh
    do_reset();
    step(79);
    chk("post_debt3", 32'(refr_debt), 3);
    chk("post_urg0", 32'(refr_urgent), 0);
    step(1);
    chk("post_debt4", 32'(refr_debt), 4);
    chk("post_urg1", 32'(refr_urgent), 1);
    chk("post_req", 32'(refr_req), 1);
    burst("post", 4);
    chk("post_debt0", 32'(refr_debt), 0);
    chk("post_ovf", 32'(refr_ovf), 0);
    chk("post_urg_end", 32'(refr_urgent), 0);
    refr_en = 1'b0;
    step(1);
    chk("post_idle_end", 32'(refr_end), 0);

    // overflow
    do_reset();
    step(99);
    chk("ovf_pre", 32'(refr_ovf), 0);
    chk("ovf_pre_debt", 32'(refr_debt), 4);
    step(1);
    chk("ovf_set", 32'(refr_ovf), 1);
    chk("ovf_debt", 32'(refr_debt), 4);
    chk("ovf_urg", 32'(refr_urgent), 1);
    burst("ovf", 4);
    chk("ovf_debt0", 32'(refr_debt), 0);
    chk("ovf_sticky", 32'(refr_ovf), 1);
    refr_en = 1'b0;
    step(1);
    chk("ovf_sticky2", 32'(refr_ovf), 1);

    // abort after first AREF
    do_reset();
    step(60);
    chk("abt_debt3", 32'(refr_debt), 3);
    refr_en = 1'b1;
    step(3);
    chk("abt_aref", 32'(refr_cmd), 32'(CMD_AREF));
    step(1);
    chk("abt_nop", 32'(refr_cmd), 32'(CMD_NOP));
    refr_en = 1'b0;
    step(1);
    chk("abt_cmd", 32'(refr_cmd), 32'(CMD_NOP));
    chk("abt_st", 32'(dut.state), 32'(ST_IDLE));
    chk("abt_end", 32'(refr_end), 0);
    chk("abt_debt", 32'(refr_debt), 2);
    chk("abt_req", 32'(refr_req), 1);
    step(2);
    chk("abt_cmd2", 32'(refr_cmd), 32'(CMD_NOP));
    chk("abt_end2", 32'(refr_end), 0);

    // reset during WAIT_RP
    do_reset();
    step(20);
    refr_en = 1'b1;
    step(2);
    chk("mrst_st", 32'(dut.state), 32'(ST_WAIT_RP));
    sys_rst = 1'b1;
    step(1);
    chk("mrst_cmd", 32'(refr_cmd), 32'(CMD_NOP));
    chk("mrst_debt", 32'(refr_debt), 0);
    chk("mrst_req", 32'(refr_req), 0);
    chk("mrst_st2", 32'(dut.state), 32'(ST_IDLE));
    chk("mrst_end", 32'(refr_end), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("mrst_noaref%0d", i), 32'(refr_cmd), 32'(CMD_NOP));
    end
    refr_en = 1'b0;
    sys_rst = 1'b0;
    step(2);
    chk("mrst_after", 32'(refr_cmd), 32'(CMD_NOP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
